// File: rtl/fp_arb_pkg.sv
// fp_arb_pkg: shared widths, FSM state encoding and operand record for the
// two-requester floating-point adder arbiter.
//   MAN_W  mantissa width
//   EXP_W  exponent width
//   N_REQ  number of requesters sharing the adder
package fp_arb_pkg;

    localparam int unsigned MAN_W = 16;
    localparam int unsigned EXP_W = 8;
    localparam int unsigned N_REQ = 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_RESP
    } state_t;

    typedef struct packed {
        logic [MAN_W-1:0] man;
        logic             sign;
        logic [EXP_W-1:0] exp;
    } operand_t;

endpackage

// File: rtl/floatingptoper.sv
// floatingptoper: combinational floating-point adder.
// Value of an operand is (-1)^sign * man * 2^exp (no hidden bit).
// The smaller-exponent operand is right-aligned to the larger exponent
// (shifts of 16 or more flush it to zero). Equal signs add, with a carry
// out renormalised by one place; unequal signs subtract the smaller
// magnitude from the larger and take the sign of the larger.
// Ports:
//   a_man/a_sign/a_exp   operand A
//   b_man/b_sign/b_exp   operand B
//   res_man/res_sign/res_exp  sum
module floatingptoper
    import fp_arb_pkg::*;
(
    input  logic [MAN_W-1:0] a_man,
    input  logic             a_sign,
    input  logic [EXP_W-1:0] a_exp,
    input  logic [MAN_W-1:0] b_man,
    input  logic             b_sign,
    input  logic [EXP_W-1:0] b_exp,
    output logic [MAN_W-1:0] res_man,
    output logic             res_sign,
    output logic [EXP_W-1:0] res_exp
);

    logic             swap;
    logic [MAN_W-1:0] big_man;
    logic [MAN_W-1:0] small_man;
    logic             big_sign;
    logic             small_sign;
    logic [EXP_W-1:0] big_exp;
    logic [EXP_W-1:0] diff;
    logic [MAN_W-1:0] aligned;
    logic [MAN_W:0]   sum;

    always_comb begin
        // Ties on exponent keep A as the reference operand.
        swap       = (b_exp > a_exp);
        big_man    = swap ? b_man  : a_man;
        small_man  = swap ? a_man  : b_man;
        big_sign   = swap ? b_sign : a_sign;
        small_sign = swap ? a_sign : b_sign;
        big_exp    = swap ? b_exp  : a_exp;
        diff       = big_exp - (swap ? a_exp : b_exp);
        aligned    = (diff > EXP_W'(MAN_W - 1)) ? '0 : (small_man >> diff);

        sum      = '0;
        res_man  = '0;
        res_sign = big_sign;
        res_exp  = big_exp;
        if (big_sign == small_sign) begin
            sum = {1'b0, big_man} + {1'b0, aligned};
            if (sum[MAN_W]) begin
                res_man = sum[MAN_W:1];
                res_exp = big_exp + 1'b1;
            end else begin
                res_man = sum[MAN_W-1:0];
            end
        end else if (big_man >= aligned) begin
            res_man = big_man - aligned;
        end else begin
            res_man  = aligned - big_man;
            res_sign = small_sign;
        end
    end

endmodule

// File: rtl/rr_arb2.sv
// rr_arb2: combinational two-way round-robin grant.
// Ports:
//   req   request vector, bit i = requester i
//   last  index of the requester served most recently
//   gnt   one-hot grant
//   idx   index of the granted requester (0 when nothing is granted)
//   any   a grant is being issued
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt,
    output logic       idx,
    output logic       any
);

    always_comb begin
        gnt = '0;
        idx = 1'b0;
        case (req)
            2'b01: begin
                gnt = 2'b01;
                idx = 1'b0;
            end
            2'b10: begin
                gnt = 2'b10;
                idx = 1'b1;
            end
            2'b11: begin
                // Contention goes to whoever was not served last.
                idx = ~last;
                gnt = last ? 2'b01 : 2'b10;
            end
            default: begin
                gnt = '0;
                idx = 1'b0;
            end
        endcase
        any = |req;
    end

endmodule

// File: rtl/fp_add_arbiter.sv
// fp_add_arbiter: shares one combinational floatingptoper between two
// requesters with round-robin arbitration and valid/ready handshakes.
// The adder sits between operand and result registers and is given LAT
// cycles to settle (multicycle path).
// Parameters:
//   LAT    adder settle window in cycles, 1..15
//   CNT_W  grant counter width (FP_ARB_STATS_EN builds only)
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      request handshake, bit i = requester i
//   req_a_*/req_b_*          packed operands, requester i in slice i
//   rsp_valid/rsp_ready      response handshake, one-hot owner
//   rsp_man/rsp_sign/rsp_exp registered result
//   busy                     FSM is not idle
//   grant_cnt0/grant_cnt1    saturating accept counters (FP_ARB_STATS_EN)
// Build option: define FP_ARB_STATS_EN to add the grant counters.
module fp_add_arbiter
    import fp_arb_pkg::*;
#(
    parameter int unsigned LAT = 2
`ifdef FP_ARB_STATS_EN
    ,
    parameter int unsigned CNT_W = 16
`endif
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*MAN_W-1:0] req_a_man,
    input  logic [N_REQ-1:0]       req_a_sign,
    input  logic [N_REQ*EXP_W-1:0] req_a_exp,
    input  logic [N_REQ*MAN_W-1:0] req_b_man,
    input  logic [N_REQ-1:0]       req_b_sign,
    input  logic [N_REQ*EXP_W-1:0] req_b_exp,
    output logic [N_REQ-1:0]       rsp_valid,
    input  logic [N_REQ-1:0]       rsp_ready,
    output logic [MAN_W-1:0]       rsp_man,
    output logic                   rsp_sign,
    output logic [EXP_W-1:0]       rsp_exp,
    output logic                   busy
`ifdef FP_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0]       grant_cnt0,
    output logic [CNT_W-1:0]       grant_cnt1
`endif
);

    localparam int unsigned SETTLE_W = 4;

    state_t              state;
    logic                last_grant;
    logic                owner;
    logic [SETTLE_W-1:0] cnt;
    operand_t            opa;
    operand_t            opb;

    operand_t            in_a [N_REQ];
    operand_t            in_b [N_REQ];

    logic [N_REQ-1:0]    gnt;
    logic                gidx;
    logic                gany;
    logic                accept;

    logic [MAN_W-1:0]    add_man;
    logic                add_sign;
    logic [EXP_W-1:0]    add_exp;

    always_comb begin
        for (int unsigned i = 0; i < N_REQ; i++) begin
            in_a[i].man  = req_a_man[MAN_W*i +: MAN_W];
            in_a[i].sign = req_a_sign[i];
            in_a[i].exp  = req_a_exp[EXP_W*i +: EXP_W];
            in_b[i].man  = req_b_man[MAN_W*i +: MAN_W];
            in_b[i].sign = req_b_sign[i];
            in_b[i].exp  = req_b_exp[EXP_W*i +: EXP_W];
        end
    end

    rr_arb2 u_arb (
        .req  (req_valid),
        .last (last_grant),
        .gnt  (gnt),
        .idx  (gidx),
        .any  (gany)
    );

    floatingptoper u_add (
        .a_man    (opa.man),
        .a_sign   (opa.sign),
        .a_exp    (opa.exp),
        .b_man    (opb.man),
        .b_sign   (opb.sign),
        .b_exp    (opb.exp),
        .res_man  (add_man),
        .res_sign (add_sign),
        .res_exp  (add_exp)
    );

    always_comb begin
        req_ready = (state == S_IDLE) ? gnt : '0;
        accept    = (state == S_IDLE) && gany;
        busy      = (state != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            cnt        <= '0;
            opa        <= '0;
            opb        <= '0;
            rsp_valid  <= '0;
            rsp_man    <= '0;
            rsp_sign   <= 1'b0;
            rsp_exp    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        opa   <= in_a[gidx];
                        opb   <= in_b[gidx];
                        owner <= gidx;
                        cnt   <= SETTLE_W'(LAT - 1);
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    // Adder outputs are only trusted on the final settle cycle.
                    if (cnt == '0) begin
                        rsp_man   <= add_man;
                        rsp_sign  <= add_sign;
                        rsp_exp   <= add_exp;
                        rsp_valid <= owner ? 2'b10 : 2'b01;
                        state     <= S_RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready[owner]) begin
                        rsp_valid  <= '0;
                        last_grant <= owner;
                        state      <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef FP_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else if (accept) begin
            if (!gidx && (grant_cnt0 != '1)) grant_cnt0 <= grant_cnt0 + 1'b1;
            if (gidx && (grant_cnt1 != '1))  grant_cnt1 <= grant_cnt1 + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fp_add_arbiter.sv
// tb_fp_add_arbiter: directed self-checking bench for fp_add_arbiter.
// Define FP_ARB_STATS_EN to also exercise the grant counters (CNT_W=2).
module tb_fp_add_arbiter;

    localparam int unsigned LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [31:0] req_a_man;
    logic [1:0]  req_a_sign;
    logic [15:0] req_a_exp;
    logic [31:0] req_b_man;
    logic [1:0]  req_b_sign;
    logic [15:0] req_b_exp;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [15:0] rsp_man;
    logic        rsp_sign;
    logic [7:0]  rsp_exp;
    logic        busy;
`ifdef FP_ARB_STATS_EN
    logic [1:0]  grant_cnt0;
    logic [1:0]  grant_cnt1;
`endif

    int npass  = 0;
    int ntotal = 0;
    int cyc_n  = 0;

    fp_add_arbiter #(
        .LAT(LAT)
`ifdef FP_ARB_STATS_EN
        ,
        .CNT_W(2)
`endif
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a_man  (req_a_man),
        .req_a_sign (req_a_sign),
        .req_a_exp  (req_a_exp),
        .req_b_man  (req_b_man),
        .req_b_sign (req_b_sign),
        .req_b_exp  (req_b_exp),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_man    (rsp_man),
        .rsp_sign   (rsp_sign),
        .rsp_exp    (rsp_exp),
        .busy       (busy)
`ifdef FP_ARB_STATS_EN
        ,
        .grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        ntotal++;
        assert (obs === expv) npass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [49:0] ops(input int i);
        return {req_a_man[16*i +: 16], req_a_sign[i], req_a_exp[8*i +: 8],
                req_b_man[16*i +: 16], req_b_sign[i], req_b_exp[8*i +: 8]};
    endfunction

    // Bench-side requester discipline: a pending request must hold still.
    logic [1:0]  pv = '0;
    logic [1:0]  pr = '0;
    logic [49:0] pops [2];
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst && pv[i] && !pr[i]) begin
                assert (req_valid[i] && (ops(i) === pops[i]))
                else begin
                    ntotal++;
                    $error("FAIL requester_rule r%0d: valid=%b ops=0x%0h required stable 0x%0h",
                           i, req_valid[i], ops(i), pops[i]);
                end
            end
            pops[i] <= ops(i);
        end
        pv <= req_valid;
        pr <= req_ready;
    end

    task automatic set_req(input int i,
                           input logic [15:0] a_m, input logic a_s, input logic [7:0] a_e,
                           input logic [15:0] b_m, input logic b_s, input logic [7:0] b_e);
        req_a_man[16*i +: 16] = a_m;
        req_a_sign[i]         = a_s;
        req_a_exp[8*i +: 8]   = a_e;
        req_b_man[16*i +: 16] = b_m;
        req_b_sign[i]         = b_s;
        req_b_exp[8*i +: 8]   = b_e;
    endtask

    // One isolated operation on requester i with a hand-computed result.
    task automatic run_op(input string tag, input int i,
                          input logic [15:0] a_m, input logic a_s, input logic [7:0] a_e,
                          input logic [15:0] b_m, input logic b_s, input logic [7:0] b_e,
                          input logic [15:0] e_m, input logic e_s, input logic [7:0] e_e);
        int n;
        logic [1:0] onehot;
        onehot = (i == 0) ? 2'b01 : 2'b10;
        set_req(i, a_m, a_s, a_e, b_m, b_s, b_e);
        req_valid[i] = 1'b1;
        #1;
        n = 0;
        while (req_ready[i] !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check({tag, "_req_ready"}, req_ready, onehot);
        step();
        req_valid[i] = 1'b0;
        check({tag, "_busy"}, busy, 1);
        n = 0;
        while (rsp_valid === 2'b00 && n < 20) begin
            step();
            n++;
        end
        check({tag, "_latency"}, n, LAT);
        check({tag, "_rsp_valid"}, rsp_valid, onehot);
        check({tag, "_rsp_man"}, rsp_man, e_m);
        check({tag, "_rsp_sign"}, rsp_sign, e_s);
        check({tag, "_rsp_exp"}, rsp_exp, e_e);
        rsp_ready[i] = 1'b1;
        step();
        rsp_ready[i] = 1'b0;
        check({tag, "_idle"}, {rsp_valid, busy}, 3'b000);
    endtask

    initial begin
        int n, acc, rsp, last_t, guard;
        logic seen;

        rst        = 1'b1;
        req_valid  = '0;
        rsp_ready  = '0;
        req_a_man  = '0;
        req_a_sign = '0;
        req_a_exp  = '0;
        req_b_man  = '0;
        req_b_sign = '0;
        req_b_exp  = '0;
        step();
        step();

        // Reset state
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_man", rsp_man, 0);
        check("rst_rsp_sign", rsp_sign, 0);
        check("rst_rsp_exp", rsp_exp, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;

        // Single request from r0: 0x0B + 0x07 at exponent 11
        run_op("single", 0, 16'h000B, 1'b0, 8'd11, 16'h0007, 1'b0, 8'd11,
               16'h0012, 1'b0, 8'd11);

        // Reset while r1's operation is in EXEC
        set_req(1, 16'h0100, 1'b0, 8'd5, 16'h0001, 1'b0, 8'd5);
        req_valid = 2'b10;
        #1;
        check("rstx_req_ready", req_ready, 2'b10);
        step();
        req_valid = 2'b00;
        step();
        check("rstx_in_exec", {busy, rsp_valid}, 3'b100);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rstx_outputs", {req_ready, rsp_valid, rsp_man, rsp_sign, rsp_exp, busy}, 0);
        seen = 1'b0;
        rsp_ready = 2'b11;
        for (int k = 0; k < 6; k++) begin
            step();
            if (rsp_valid !== 2'b00 || busy !== 1'b0) seen = 1'b1;
        end
        rsp_ready = 2'b00;
        check("rstx_no_rsp", seen, 0);

        // Contention: both valid, rsp_ready held high; order 0,1,0,1
        set_req(0, 16'h000B, 1'b0, 8'd11, 16'h0007, 1'b0, 8'd11);
        set_req(1, 16'hFFFF, 1'b0, 8'd3, 16'h0001, 1'b0, 8'd3);
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        #1;
        acc = 0;
        rsp = 0;
        last_t = 0;
        guard = 0;
        while ((acc < 4 || rsp < 4) && guard < 60) begin
            if (req_ready !== 2'b00 && acc < 4) begin
                check("cont_grant", req_ready, (acc % 2 == 0) ? 2'b01 : 2'b10);
                if (acc > 0) check("cont_gap", cyc_n - last_t, LAT + 2);
                last_t = cyc_n;
                acc++;
            end
            if (rsp_valid !== 2'b00) begin
                check("cont_rsp_owner", rsp_valid, (rsp % 2 == 0) ? 2'b01 : 2'b10);
                check("cont_rsp_man", rsp_man, (rsp % 2 == 0) ? 16'h0012 : 16'h8000);
                check("cont_rsp_exp", rsp_exp, (rsp % 2 == 0) ? 8'd11 : 8'd4);
                rsp++;
            end
            step();
            guard++;
            if (acc >= 3) req_valid[0] = 1'b0;
            if (acc >= 4) req_valid[1] = 1'b0;
        end
        check("cont_complete", {acc[7:0], rsp[7:0]}, {8'd4, 8'd4});
        rsp_ready = 2'b00;
        step();

        // Backpressure: r0 owns RESP for 5 cycles while r1 waits
        set_req(0, 16'h0005, 1'b0, 8'd4, 16'h0009, 1'b1, 8'd4);
        req_valid = 2'b01;
        #1;
        check("bp_req_ready0", req_ready, 2'b01);
        step();
        req_valid[0] = 1'b0;
        set_req(1, 16'h030F, 1'b0, 8'd9, 16'h000F, 1'b0, 8'd11);
        req_valid[1] = 1'b1;
        rsp_ready = 2'b10;
        n = 0;
        while (rsp_valid === 2'b00 && n < 20) begin
            step();
            n++;
        end
        check("bp_latency", n, LAT);
        for (int k = 0; k < 5; k++) begin
            check("bp_hold", {rsp_valid, rsp_man, rsp_sign, rsp_exp, req_ready, busy},
                  {2'b01, 16'h0004, 1'b1, 8'd4, 2'b00, 1'b1});
            step();
        end
        rsp_ready = 2'b01;
        step();
        rsp_ready = 2'b00;
        check("bp_idle", {req_ready, rsp_valid, busy}, {2'b10, 2'b00, 1'b0});
        step();
        req_valid[1] = 1'b0;
        check("bp_r1_accepted", busy, 1);
        n = 0;
        while (rsp_valid === 2'b00 && n < 20) begin
            step();
            n++;
        end
        check("bp_r1_rsp", {rsp_valid, rsp_man, rsp_sign, rsp_exp}, {2'b10, 16'h00D2, 1'b0, 8'd11});
        rsp_ready = 2'b10;
        step();
        rsp_ready = 2'b00;

        // Operand coverage
        run_op("cov_align", 1, 16'h030F, 1'b0, 8'd9, 16'h000F, 1'b0, 8'd11,
               16'h00D2, 1'b0, 8'd11);
        run_op("cov_zero", 1, 16'h0000, 1'b0, 8'd17, 16'h0000, 1'b0, 8'd11,
               16'h0000, 1'b0, 8'd17);
        run_op("cov_carry", 0, 16'hFFFF, 1'b0, 8'd3, 16'h0001, 1'b0, 8'd3,
               16'h8000, 1'b0, 8'd4);
        run_op("cov_sub_neg", 0, 16'h0005, 1'b0, 8'd4, 16'h0009, 1'b1, 8'd4,
               16'h0004, 1'b1, 8'd4);
        run_op("cov_sub_swap", 1, 16'h0010, 1'b1, 8'd5, 16'h0100, 1'b0, 8'd7,
               16'h00FC, 1'b0, 8'd7);
        run_op("cov_flush", 0, 16'h8000, 1'b0, 8'd30, 16'hFFFF, 1'b1, 8'd2,
               16'h8000, 1'b0, 8'd30);

`ifdef FP_ARB_STATS_EN
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("stats_rst", {grant_cnt0, grant_cnt1}, 4'b0000);
        for (int k = 0; k < 3; k++)
            run_op("stats_r0", 0, 16'h0001, 1'b0, 8'd1, 16'h0001, 1'b0, 8'd1,
                   16'h0002, 1'b0, 8'd1);
        for (int k = 0; k < 2; k++)
            run_op("stats_r1", 1, 16'h0002, 1'b0, 8'd1, 16'h0002, 1'b0, 8'd1,
                   16'h0004, 1'b0, 8'd1);
        check("stats_cnt0", grant_cnt0, 3);
        check("stats_cnt1", grant_cnt1, 2);
        for (int k = 0; k < 2; k++)
            run_op("stats_sat", 0, 16'h0001, 1'b0, 8'd1, 16'h0001, 1'b0, 8'd1,
                   16'h0002, 1'b0, 8'd1);
        check("stats_cnt0_sat", grant_cnt0, 3);
        check("stats_cnt1_hold", grant_cnt1, 2);
`endif

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation reached 200000 time units, required completion earlier");
        $fatal(1);
    end

endmodule
